// File: rtl/obi_rready_buffer_pkg.sv
// rtl/obi_rready_buffer_pkg.sv - OBI config, channel structs and helpers for the rready buffer
package obi_rready_buffer_pkg;

    // OBI port configuration
    typedef struct packed {
        logic        use_rready;
        logic        integrity;
        int unsigned addr_width;
        int unsigned data_width;
        int unsigned id_width;
    } obi_cfg_t;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 4;

    localparam obi_cfg_t ObiDefaultConfig = '{
        use_rready: 1'b0,
        integrity:  1'b0,
        addr_width: AddrWidth,
        data_width: DataWidth,
        id_width:   IdWidth
    };

    localparam obi_cfg_t ObiRReadyConfig = '{
        use_rready: 1'b1,
        integrity:  1'b0,
        addr_width: AddrWidth,
        data_width: DataWidth,
        id_width:   IdWidth
    };

    // A channel: address, write control, id and atomic opcode
    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
        logic [5:0]             atop;
    } obi_a_chan_t;

    // R channel: read data, id and error flag
    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_sbr_req_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_sbr_rsp_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_mgr_req_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_mgr_rsp_t;

    // Bits needed to count 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// rtl/obi_rsp_fifo.sv - Depth-entry registered FIFO holding OBI R-channel responses
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   push, wdata   write one entry (caller guarantees room)
//   pop           remove head entry (ignored when empty)
//   rdata         head entry
//   full, empty   occupancy flags
module obi_rsp_fifo
    import obi_rready_buffer_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         data_t = obi_r_chan_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push,
    input  data_t wdata,
    input  logic  pop,
    output data_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = cnt_width(Depth);

    data_t            mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             pop_ok;

    // Pointers wrap at Depth, which need not be a power of two
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full   = (cnt_q == CntW'(Depth));
    assign empty  = (cnt_q == '0);
    assign pop_ok = pop & ~empty;
    assign rdata  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= next_ptr(wptr_q);
            end
            if (pop_ok) begin
                rptr_q <= next_ptr(rptr_q);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/obi_rready_buffer.sv
// rtl/obi_rready_buffer.sv - lets an rready-capable OBI manager drive a shim without rready
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   sbr_req_i  upstream request (req, a channel, rready)
//   sbr_rsp_o  upstream response (gnt, rvalid, r channel)
//   mgr_req_o  downstream request to the SRAM shim
//   mgr_rsp_i  downstream response (gnt, rvalid one cycle after grant, r channel)
module obi_rready_buffer
    import obi_rready_buffer_pkg::*;
#(
    parameter obi_cfg_t    SbrCfg    = ObiRReadyConfig,
    parameter obi_cfg_t    MgrCfg    = ObiDefaultConfig,
    parameter type         sbr_req_t = obi_sbr_req_t,
    parameter type         sbr_rsp_t = obi_sbr_rsp_t,
    parameter type         mgr_req_t = obi_mgr_req_t,
    parameter type         mgr_rsp_t = obi_mgr_rsp_t,
    parameter int unsigned Depth     = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  sbr_req_t sbr_req_i,
    output sbr_rsp_t sbr_rsp_o,
    output mgr_req_t mgr_req_o,
    input  mgr_rsp_t mgr_rsp_i
);

    localparam int unsigned CntW = cnt_width(Depth);

    if (Depth < 1) begin : gen_bad_depth
        $error("obi_rready_buffer: Depth must be at least 1");
    end
    if (SbrCfg.integrity || MgrCfg.integrity) begin : gen_bad_integrity
        $error("obi_rready_buffer: integrity checking is not supported");
    end
    if (!SbrCfg.use_rready || MgrCfg.use_rready) begin : gen_bad_rready
        $error("obi_rready_buffer: upstream needs rready, downstream must not use it");
    end
    if (SbrCfg.addr_width != MgrCfg.addr_width ||
        SbrCfg.data_width != MgrCfg.data_width ||
        SbrCfg.id_width   != MgrCfg.id_width) begin : gen_bad_widths
        $error("obi_rready_buffer: upstream and downstream widths must match");
    end

    // Outstanding transactions: in flight at the shim plus held in the FIFO
    logic [CntW-1:0] cnt_q;
    logic            pop;
    logic            space;
    logic            gnt;
    logic            hs;
    logic            fifo_full;
    logic            fifo_empty;
    obi_r_chan_t     fifo_head;

    assign pop   = ~fifo_empty & sbr_req_i.rready;
    // A pop this cycle frees a slot, so rready feeds gnt combinationally
    // to sustain one transaction per cycle even at Depth=2.
    assign space = (cnt_q < CntW'(Depth)) | pop;
    assign gnt   = mgr_rsp_i.gnt & space & ~rst_i;
    assign hs    = sbr_req_i.req & gnt;

    always_comb begin
        mgr_req_o     = '0;
        mgr_req_o.a   = sbr_req_i.a;
        mgr_req_o.req = sbr_req_i.req & space & ~rst_i;
    end

    always_comb begin
        sbr_rsp_o        = '0;
        sbr_rsp_o.gnt    = gnt;
        sbr_rsp_o.rvalid = ~fifo_empty;
        sbr_rsp_o.r      = fifo_head;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(hs) - CntW'(pop);
        end
    end

    // The shim answers exactly one cycle after grant and cannot be stalled,
    // so every rvalid is stored; the grant throttle keeps a slot free for it.
    obi_rsp_fifo #(
        .Depth  (Depth),
        .data_t (obi_r_chan_t)
    ) i_rsp_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (mgr_rsp_i.rvalid & ~rst_i),
        .wdata (mgr_rsp_i.r),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mgr_rsp_i.rvalid && fifo_full && !pop))
            else $fatal(1, "obi_rready_buffer: response pushed into full FIFO");
            assert (cnt_q <= CntW'(Depth))
            else $fatal(1, "obi_rready_buffer: outstanding count above Depth");
        end
    end

endmodule

// File: tb/tb_obi_rready_buffer.sv
// tb/tb_obi_rready_buffer.sv - directed self-checking bench for obi_rready_buffer
module tb_obi_rready_buffer;
    import obi_rready_buffer_pkg::*;

    logic clk;
    logic rst;

    obi_sbr_req_t sbr_req, sbr_req3;
    obi_sbr_rsp_t sbr_rsp, sbr_rsp3;
    obi_mgr_req_t mgr_req, mgr_req3;
    obi_mgr_rsp_t mgr_rsp, mgr_rsp3;

    logic        shim_gnt;
    logic        shim_err;
    logic        shim_rv, shim_rv3;
    obi_r_chan_t shim_r, shim_r3;

    int passed = 0;
    int total  = 0;

    obi_rready_buffer #(.Depth(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp),
        .mgr_req_o (mgr_req),
        .mgr_rsp_i (mgr_rsp)
    );

    obi_rready_buffer #(.Depth(3)) dut3 (
        .clk_i     (clk),
        .rst_i     (rst),
        .sbr_req_i (sbr_req3),
        .sbr_rsp_o (sbr_rsp3),
        .mgr_req_o (mgr_req3),
        .mgr_rsp_i (mgr_rsp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM shim model: fixed one-cycle response, rdata = addr ^ DEADBEAF
    always_ff @(posedge clk) begin
        if (rst) begin
            shim_rv  <= 1'b0;
            shim_rv3 <= 1'b0;
        end else begin
            shim_rv        <= mgr_req.req & shim_gnt;
            shim_r.rdata   <= mgr_req.a.addr ^ 32'hDEADBEAF;
            shim_r.rid     <= mgr_req.a.aid;
            shim_r.err     <= shim_err;
            shim_rv3       <= mgr_req3.req & shim_gnt;
            shim_r3.rdata  <= mgr_req3.a.addr ^ 32'hDEADBEAF;
            shim_r3.rid    <= mgr_req3.a.aid;
            shim_r3.err    <= 1'b0;
        end
    end

    assign mgr_rsp  = '{r: shim_r,  gnt: shim_gnt, rvalid: shim_rv};
    assign mgr_rsp3 = '{r: shim_r3, gnt: shim_gnt, rvalid: shim_rv3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [31:0] addr,
                         input logic [3:0] aid, input logic rr);
        sbr_req.req     = r;
        sbr_req.a.we    = we;
        sbr_req.a.addr  = addr;
        sbr_req.a.aid   = aid;
        sbr_req.a.be    = 4'hF;
        sbr_req.a.wdata = ~addr;
        sbr_req.a.atop  = 6'd0;
        sbr_req.rready  = rr;
    endtask

    initial begin
        logic [3:0]  got_rid[$];
        logic [31:0] got_data[$];
        int          bubbles;
        int          grants;
        logic        have_first;
        obi_r_chan_t first_r;
        int          next_id;
        int          max_cnt;
        logic        done;

        rst      = 1'b1;
        sbr_req  = '0;
        sbr_req3 = '0;
        shim_gnt = 1'b1;
        shim_err = 1'b0;

        // Reset state, with a request pending while rst is high
        cyc();
        drive(1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
        cyc();
        #1;
        chk("reset_gnt", sbr_rsp.gnt, 0);
        chk("reset_mgr_req", mgr_req.req, 0);
        chk("reset_rvalid", sbr_rsp.rvalid, 0);
        chk("reset_cnt", dut.cnt_q, 0);
        sbr_req.req = 1'b0;
        cyc();
        rst = 1'b0;

        // Single read: gnt in N, rvalid in N+2, count back to 0 in N+3
        cyc();
        drive(1'b1, 1'b0, 32'h40, 4'd3, 1'b1);
        #1;
        chk("single_gnt", sbr_rsp.gnt, 1);
        chk("single_mgr_req", mgr_req.req, 1);
        cyc();
        sbr_req.req = 1'b0;
        #1;
        chk("single_no_fallthrough", sbr_rsp.rvalid, 0);
        cyc();
        #1;
        chk("single_rvalid", sbr_rsp.rvalid, 1);
        chk("single_rdata", sbr_rsp.r.rdata, 32'hDEADBEEF);
        chk("single_rid", sbr_rsp.r.rid, 3);
        cyc();
        #1;
        chk("single_cnt_zero", dut.cnt_q, 0);
        chk("single_rvalid_low", sbr_rsp.rvalid, 0);

        // Streaming: 8 back-to-back reads with rready held high
        bubbles = 0;
        for (int k = 0; k < 14; k++) begin
            cyc();
            if (k < 8) drive(1'b1, 1'b0, 32'(k * 4), 4'(k), 1'b1);
            else       sbr_req.req = 1'b0;
            #1;
            if (k < 8 && !sbr_rsp.gnt) bubbles++;
            if (sbr_rsp.rvalid && sbr_req.rready) begin
                got_rid.push_back(sbr_rsp.r.rid);
                got_data.push_back(sbr_rsp.r.rdata);
            end
        end
        chk("stream_bubbles", bubbles, 0);
        chk("stream_count", got_rid.size(), 8);
        for (int i = 0; i < 8 && i < got_rid.size(); i++) begin
            chk($sformatf("stream_rid%0d", i), got_rid[i], i);
            chk($sformatf("stream_data%0d", i), got_data[i], 32'(i * 4) ^ 32'hDEADBEAF);
        end

        // Backpressure: rready low, req held high
        grants     = 0;
        have_first = 1'b0;
        first_r    = '0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            drive(1'b1, 1'b0, 32'h100, 4'd5, 1'b0);
            #1;
            if (sbr_rsp.gnt) grants++;
            if (k >= 2) begin
                chk($sformatf("bp_gnt_low%0d", k), sbr_rsp.gnt, 0);
                chk($sformatf("bp_mgr_req_low%0d", k), mgr_req.req, 0);
            end
            if (sbr_rsp.rvalid) begin
                if (!have_first) begin
                    first_r    = sbr_rsp.r;
                    have_first = 1'b1;
                end else begin
                    chk($sformatf("bp_r_stable%0d", k), sbr_rsp.r, first_r);
                end
            end
        end
        chk("bp_grants", grants, 2);
        chk("bp_rvalid_seen", have_first, 1);
        cyc();
        drive(1'b1, 1'b0, 32'h104, 4'd6, 1'b1);
        #1;
        chk("bp_pop_and_gnt", sbr_rsp.gnt, 1);
        chk("bp_pop_rid", sbr_rsp.r.rid, 5);
        got_rid.delete();
        for (int k = 0; k < 6; k++) begin
            cyc();
            sbr_req.req = 1'b0;
            #1;
            if (sbr_rsp.rvalid && sbr_req.rready) got_rid.push_back(sbr_rsp.r.rid);
        end
        chk("bp_drain_count", got_rid.size(), 2);
        if (got_rid.size() == 2) begin
            chk("bp_drain_rid0", got_rid[0], 5);
            chk("bp_drain_rid1", got_rid[1], 6);
        end

        // Full-wrap on Depth=3 with rready toggling 1,0,0,1
        got_rid.delete();
        got_data.delete();
        next_id = 0;
        max_cnt = 0;
        done    = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            cyc();
            sbr_req3.req       = (next_id < 10);
            sbr_req3.a         = '0;
            sbr_req3.a.aid     = 4'(next_id);
            sbr_req3.a.addr    = 32'(next_id * 8);
            sbr_req3.rready    = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (int'(dut3.cnt_q) > max_cnt) max_cnt = int'(dut3.cnt_q);
            if (sbr_req3.req && sbr_rsp3.gnt) next_id++;
            if (sbr_rsp3.rvalid && sbr_req3.rready) begin
                got_rid.push_back(sbr_rsp3.r.rid);
                got_data.push_back(sbr_rsp3.r.rdata);
            end
            if (got_rid.size() == 10) done = 1'b1;
        end
        sbr_req3 = '0;
        chk("wrap_done", done, 1);
        chk("wrap_issued", next_id, 10);
        chk("wrap_reached_full", max_cnt, 3);
        for (int i = 0; i < 10 && i < got_rid.size(); i++) begin
            chk($sformatf("wrap_rid%0d", i), got_rid[i], i);
            chk($sformatf("wrap_data%0d", i), got_data[i], 32'(i * 8) ^ 32'hDEADBEAF);
        end

        // Write with error response from downstream
        cyc();
        shim_err = 1'b1;
        drive(1'b1, 1'b1, 32'h200, 4'd9, 1'b1);
        #1;
        chk("werr_gnt", sbr_rsp.gnt, 1);
        cyc();
        shim_err    = 1'b0;
        sbr_req.req = 1'b0;
        cyc();
        #1;
        chk("werr_rvalid", sbr_rsp.rvalid, 1);
        chk("werr_err", sbr_rsp.r.err, 1);
        chk("werr_rid", sbr_rsp.r.rid, 9);
        cyc();

        // Reset mid-operation with two entries buffered
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive(1'b1, 1'b0, 32'h80, 4'hA, 1'b0);
        end
        #1;
        chk("rstmid_full_cnt", dut.cnt_q, 2);
        cyc();
        rst = 1'b1;
        #1;
        chk("rstmid_gnt", sbr_rsp.gnt, 0);
        chk("rstmid_mgr_req", mgr_req.req, 0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        #1;
        chk("rstmid_rvalid", sbr_rsp.rvalid, 0);
        chk("rstmid_cnt", dut.cnt_q, 0);
        cyc();
        drive(1'b1, 1'b0, 32'h300, 4'hB, 1'b1);
        #1;
        chk("post_rst_gnt", sbr_rsp.gnt, 1);
        cyc();
        sbr_req.req = 1'b0;
        cyc();
        #1;
        chk("post_rst_rvalid", sbr_rsp.rvalid, 1);
        chk("post_rst_rid", sbr_rsp.r.rid, 4'hB);
        chk("post_rst_rdata", sbr_rsp.r.rdata, 32'h300 ^ 32'hDEADBEAF);
        cyc();
        #1;
        chk("post_rst_cnt", dut.cnt_q, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
